mdu_ctrl: RTL and testbench

Multiply/divide unit controller for the five-stage pipeline. It owns the HI/LO registers and accepts mult/div/mthi/mtlo operations from the E stage. It sequences each multi-cycle operation with a latency counter and raises a stall request toward the F/D hazard logic while any HI/LO-dependent instruction in D would observe an unfinished result.

---
 rtl/mdu_ctrl_pkg.sv | 31 +++
 rtl/mdu_ctrl_calc.sv | 71 +++++++
 rtl/mdu_ctrl.sv | 110 +++++++++++
 tb/tb_mdu_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// ============================================================================
// Module   : mdu_ctrl_pkg
// Brief    : Shared MDU defines (md_defs): opcodes, FSM states, result type.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_ctrl_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [0:0] c_stateIdle = 1'b0;
  localparam logic [0:0] c_stateRun  = 1'b1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hiLo_t;

  function automatic logic isMulDiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_ctrl_calc.sv
// ============================================================================
// Module   : MD_CALC
// Brief    : Combinational HI/LO result generator for mult/div operations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module MD_CALC
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  iop,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic [31:0] iHI,
  input  logic [31:0] iLO,
  output hiLo_t       opend
);

  logic signed [63:0] w_sProd;
  logic        [63:0] w_uProd;
  logic signed [31:0] w_sQuo;
  logic signed [31:0] w_sRem;
  logic        [31:0] w_uQuo;
  logic        [31:0] w_uRem;
  logic               w_divZero;
  logic               w_divOvf;

  assign w_sProd   = $signed({{32{iA[31]}}, iA}) * $signed({{32{iB[31]}}, iB});
  assign w_uProd   = {32'd0, iA} * {32'd0, iB};
  assign w_sQuo    = $signed(iA) / $signed(iB);
  assign w_sRem    = $signed(iA) % $signed(iB);
  assign w_uQuo    = iA / iB;
  assign w_uRem    = iA % iB;
  assign w_divZero = (iB == 32'd0);
  assign w_divOvf  = (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);

  // A zero divisor or non-arithmetic op returns the current HI/LO unchanged.
  always_comb begin
    opend.hi = iHI;
    opend.lo = iLO;
    case (iop)
      MD_MULT: begin
        opend.hi = w_sProd[63:32];
        opend.lo = w_sProd[31:0];
      end
      MD_MULTU: begin
        opend.hi = w_uProd[63:32];
        opend.lo = w_uProd[31:0];
      end
      MD_DIV: begin
        if (w_divOvf) begin
          opend.hi = 32'd0;
          opend.lo = 32'h8000_0000;
        end else if (!w_divZero) begin
          opend.hi = w_sRem;
          opend.lo = w_sQuo;
        end
      end
      MD_DIVU: begin
        if (!w_divZero) begin
          opend.hi = w_uRem;
          opend.lo = w_uQuo;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module   : mdu_ctrl
// Brief    : HI/LO owner, multi-cycle mult/div sequencer and D-stage stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        istart,
  input  logic [2:0]  iop,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iD_md,
  output logic        obusy,
  output logic        ostall,
  output logic [31:0] oHI,
  output logic [31:0] oLO
);

  localparam int c_maxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int c_cntW      = $clog2(c_maxCycles + 1);

  logic [0:0]        r_state;
  logic [0:0]        w_nextState;
  logic [c_cntW-1:0] r_count;
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;
  hiLo_t             r_pend;
  hiLo_t             w_calc;
  logic              w_isMulDiv;
  logic              w_isMul;
  logic              w_load;
  logic              w_commit;
  logic              w_mtHi;
  logic              w_mtLo;

  assign w_isMulDiv = isMulDiv(iop);
  assign w_isMul    = (iop == MD_MULT) || (iop == MD_MULTU);

  MD_CALC u_calc (
    .iop   (iop),
    .iA    (iA),
    .iB    (iB),
    .iHI   (r_hi),
    .iLO   (r_lo),
    .opend (w_calc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_stateIdle;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_stateIdle: if (istart && w_isMulDiv)             w_nextState = c_stateRun;
      c_stateRun:  if (r_count == c_cntW'(1))            w_nextState = c_stateIdle;
      default:                                           w_nextState = c_stateIdle;
    endcase
  end

  // Issues arriving during RUN are dropped: only IDLE decodes istart.
  always_comb begin
    obusy    = (r_state == c_stateRun);
    w_load   = (r_state == c_stateIdle) && istart && w_isMulDiv;
    w_mtHi   = (r_state == c_stateIdle) && istart && (iop == MD_MTHI);
    w_mtLo   = (r_state == c_stateIdle) && istart && (iop == MD_MTLO);
    w_commit = (r_state == c_stateRun) && (r_count == c_cntW'(1));
    ostall   = iD_md && (obusy || (istart && w_isMulDiv));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_pend  <= '0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      if (w_load) begin
        r_pend  <= w_calc;
        r_count <= w_isMul ? c_cntW'(MUL_CYCLES) : c_cntW'(DIV_CYCLES);
      end else if (r_state == c_stateRun) begin
        r_count <= r_count - c_cntW'(1);
      end
      if (w_commit) begin
        r_hi <= r_pend.hi;
        r_lo <= r_pend.lo;
      end
      if (w_mtHi) r_hi <= iA;
      if (w_mtLo) r_lo <= iA;
    end
  end

  assign oHI = r_hi;
  assign oLO = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// Module   : tb_mdu_ctrl
// Brief    : Randomized self-checking bench for mdu_ctrl with arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;

  localparam int c_mulCycles = 5;
  localparam int c_divCycles = 10;

  logic        clk;
  logic        reset;
  logic        istart;
  logic [2:0]  iop;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iD_md;
  logic        obusy;
  logic        ostall;
  logic [31:0] oHI;
  logic [31:0] oLO;

  int          nVec  = 0;
  int          nFail = 0;
  logic [31:0] mHi   = 32'd0;
  logic [31:0] mLo   = 32'd0;

  mdu_ctrl #(
    .MUL_CYCLES (c_mulCycles),
    .DIV_CYCLES (c_divCycles)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .istart (istart),
    .iop    (iop),
    .iA     (iA),
    .iB     (iB),
    .iD_md  (iD_md),
    .obusy  (obusy),
    .ostall (ostall),
    .oHI    (oHI),
    .oLO    (oLO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic done in 64-bit integers straight from the ISA rules.
  task automatic refCalc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo,
                         output logic [31:0] nHi, output logic [31:0] nLo);
    longint          sa, sb, p, q, r;
    longint unsigned up;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    nHi = hi;
    nLo = lo;
    case (op)
      3'd0: begin p = sa * sb; nHi = p[63:32]; nLo = p[31:0]; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; nHi = up[63:32]; nLo = up[31:0]; end
      3'd2: begin
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            nHi = 32'd0; nLo = 32'h8000_0000;
          end else begin
            q = sa / sb; r = sa - q * sb; nHi = r[31:0]; nLo = q[31:0];
          end
        end
      end
      3'd3: if (b != 0) begin nLo = a / b; nHi = a - nLo * b; end
      3'd4: nHi = a;
      3'd5: nLo = a;
      default: ;
    endcase
  endtask

  // Issues one op at least 1 time unit before a rising edge and follows it to
  // the cycle in which HI/LO become visible, leaving the caller in that cycle.
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit dmd, input int injectAt);
    bit          md;
    int          n;
    logic [31:0] nHi, nLo;
    md = (op <= 3'd3);
    n  = (op <= 3'd1) ? c_mulCycles : c_divCycles;
    refCalc(op, a, b, mHi, mLo, nHi, nLo);
    istart = 1'b1; iop = op; iA = a; iB = b; iD_md = dmd;
    #1;
    chk("issue_busy",  obusy,  0);
    chk("issue_stall", ostall, dmd && md);
    @(posedge clk); #1;
    istart = 1'b0;
    if (md) begin
      for (int i = 0; i < n; i++) begin
        if (i == injectAt) begin
          istart = 1'b1; iop = 3'd2; iA = $urandom; iB = $urandom | 32'd1;
        end
        @(negedge clk);
        chk("run_busy",  obusy,  1);
        chk("run_stall", ostall, dmd);
        chk("run_hi",    oHI,    mHi);
        chk("run_lo",    oLO,    mLo);
        @(posedge clk); #1;
        istart = 1'b0;
      end
    end
    mHi = nHi;
    mLo = nLo;
    @(negedge clk);
    chk("done_busy",  obusy,  0);
    chk("done_stall", ostall, 0);
    chk("done_hi",    oHI,    mHi);
    chk("done_lo",    oLO,    mLo);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; istart = 1'b0; iop = 3'd0; iA = 32'd0; iB = 32'd0; iD_md = 1'b0;
    #12;
    chk("reset_busy",  obusy,  0);
    chk("reset_stall", ostall, 0);
    chk("reset_hi",    oHI,    0);
    chk("reset_lo",    oLO,    0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    runOp(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1, -1);
    chk("plan_mult_hi", oHI, 32'hFFFF_FFFF);
    chk("plan_mult_lo", oLO, 32'hFFFF_FFFE);
    runOp(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, -1);
    chk("plan_multu_hi", oHI, 32'h0000_0001);
    chk("plan_multu_lo", oLO, 32'hFFFF_FFFE);
    runOp(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    chk("plan_div_hi", oHI, 32'hFFFF_FFFF);
    chk("plan_div_lo", oLO, 32'hFFFF_FFFD);
    runOp(3'd3, 32'd7, 32'd2, 1'b1, -1);
    chk("plan_divu_hi", oHI, 32'd1);
    chk("plan_divu_lo", oLO, 32'd3);
    runOp(3'd4, 32'h1234, 32'd0, 1'b1, -1);
    runOp(3'd3, 32'd99, 32'd0, 1'b0, -1);
    chk("plan_div0_hi", oHI, 32'h1234);
    chk("plan_div0_lo", oLO, 32'd3);
    runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    chk("plan_ovf_lo", oLO, 32'h8000_0000);
    runOp(3'd0, 32'd6, 32'd7, 1'b1, 2);
    chk("plan_ignore_lo", oLO, 32'd42);

    // Reset dropped in the middle of a divide must clear outputs at once.
    runOp(3'd5, 32'hABCD, 32'd0, 1'b0, -1);
    istart = 1'b1; iop = 3'd2; iA = 32'd100; iB = 32'd3; iD_md = 1'b0;
    @(posedge clk); #1; istart = 1'b0;
    repeat (3) @(posedge clk);
    #2; reset = 1'b0;
    #1;
    chk("midrst_busy", obusy, 0);
    chk("midrst_hi",   oHI,   0);
    chk("midrst_lo",   oLO,   0);
    mHi = 32'd0; mLo = 32'd0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    runOp(3'd0, 32'd3, 32'd4, 1'b0, -1);
    chk("postrst_lo", oLO, 32'd12);

    for (int k = 0; k < 60; k++) begin
      runOp(3'($urandom_range(0, 7)), rnd32(), rnd32(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

`default_nettype wire
